// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared constants for the writeback region of the core:
//   - DATABUS       : architectural data width
//   - WB_*          : writeback-mux select encodings
//   - arb_state_e   : register-file write-port arbitration states
// ---------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int DATABUS = 16;

  // Writeback mux select encodings
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  // Write-port arbitration states.
  // ARB_NORMAL: pipe has priority, the MDU FIFO fills idle slots.
  // ARB_FORCE : the FIFO head wins for one cycle and the pipe is stalled.
  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// Small synchronous FIFO holding MDU results ({rd, data}) until they get a
// register-file write slot. The head entry is readable combinationally so the
// arbiter can grant it in the same cycle it becomes visible.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   W-bit entry
//   pop        in   remove the head entry (ignored when empty)
//   head_data  out  current head entry (valid when cnt != 0)
//   cnt        out  registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int W     = 21,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;

  logic do_push;
  logic do_pop;

  assign do_push = push & (cnt_reg != CW'(DEPTH));
  assign do_pop  = pop  & (cnt_reg != '0);

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign cnt       = cnt_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order writeback
// stage and the multi-cycle MDU. MDU results queue in a small FIFO and drain
// into idle write slots; if the FIFO head waits STARVE_MAX cycles it is forced
// through for one cycle while the pipe is stalled. All rf_* outputs are
// registered (one cycle from grant to rf_we).
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   pipe_valid  in   WB stage has a write this cycle
//   pipe_rd     in   WB destination register
//   pipe_data   in   WB write data
//   flush       in   kill the current pipe request (FIFO unaffected)
//   pipe_stall  out  pipe request not accepted; WB must hold it
//   mdu_valid   in   MDU result available
//   mdu_ready   out  FIFO can accept a result
//   mdu_rd      in   MDU destination register
//   mdu_data    in   MDU result
//   rf_we       out  register-file write enable
//   rf_waddr    out  register-file write address
//   rf_wdata    out  register-file write data
//   fifo_cnt    out  FIFO occupancy for issue/hazard logic
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW         = DATABUS,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_valid,
  input  logic [AW-1:0]          pipe_rd,
  input  logic [DW-1:0]          pipe_data,
  input  logic                   flush,
  output logic                   pipe_stall,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [AW-1:0]          mdu_rd,
  input  logic [DW-1:0]          mdu_data,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = AW + DW;
  localparam int AGE_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(STARVE_MAX - 1);

  arb_state_e       state_reg;
  arb_state_e       state_next;
  logic [AGE_W-1:0] age_reg;
  logic [AGE_W-1:0] age_next;

  logic             rf_we_reg;
  logic [AW-1:0]    rf_waddr_reg;
  logic [DW-1:0]    rf_wdata_reg;

  logic [CW-1:0]    cnt;
  logic [EW-1:0]    head_entry;
  logic [AW-1:0]    head_rd;
  logic [DW-1:0]    head_data;

  logic             pipe_req;
  logic             head_valid;
  logic             grant_pipe;
  logic             grant_head;
  logic             push;

  // -------------------------------------------------------------------------
  // MDU result FIFO
  // -------------------------------------------------------------------------
  assign mdu_ready = (cnt != CW'(DEPTH));
  assign push      = mdu_valid & mdu_ready;

  wb_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({mdu_rd, mdu_data}),
    .pop       (grant_head),
    .head_data (head_entry),
    .cnt       (cnt)
  );

  assign head_rd    = head_entry[EW-1:DW];
  assign head_data  = head_entry[DW-1:0];
  assign head_valid = (cnt != '0);
  assign pipe_req   = pipe_valid & ~flush;
  assign fifo_cnt   = cnt;

  // -------------------------------------------------------------------------
  // Arbitration FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_NORMAL;
      age_reg   <= '0;
    end else begin
      state_reg <= state_next;
      age_reg   <= age_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_pipe = 1'b0;
    grant_head = 1'b0;
    pipe_stall = 1'b0;
    case (state_reg)
      ARB_NORMAL: begin
        if (pipe_req) begin
          grant_pipe = 1'b1;
        end else if (head_valid) begin
          grant_head = 1'b1;
        end
        // Head has already been passed over STARVE_MAX-1 times and loses
        // again now: it wins the next cycle unconditionally.
        if (head_valid && (age_reg == AGE_LAST) && !grant_head) begin
          state_next = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        // The head cannot have left the FIFO since FORCE was decided
        // (only pops remove entries), so head_valid holds here.
        grant_head = head_valid;
        pipe_stall = pipe_req;
        state_next = ARB_NORMAL;
      end
      default: begin
        state_next = ARB_NORMAL;
      end
    endcase
  end

  // Age of the current head: how many cycles it has been passed over.
  always_comb begin
    age_next = age_reg;
    if (grant_head || !head_valid) begin
      age_next = '0;
    end else if (age_reg != AGE_LAST) begin
      age_next = age_reg + AGE_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registered write port. Writes to x0 consume the slot but are suppressed;
  // address/data hold their last values when nothing is granted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      if (grant_head) begin
        rf_we_reg    <= (head_rd != '0);
        rf_waddr_reg <= head_rd;
        rf_wdata_reg <= head_data;
      end else if (grant_pipe) begin
        rf_we_reg    <= (pipe_rd != '0);
        rf_waddr_reg <= pipe_rd;
        rf_wdata_reg <= pipe_data;
      end else begin
        rf_we_reg    <= 1'b0;
      end
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios plus random traffic against a queue-based reference
// model of the write-port arbitration rules.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int DW         = 16;
  localparam int AW         = 5;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_valid;
  logic [AW-1:0] pipe_rd;
  logic [DW-1:0] pipe_data;
  logic          flush;
  logic          pipe_stall;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_rd;
  logic [DW-1:0] mdu_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [$clog2(DEPTH):0] fifo_cnt;

  wb_port_arbiter #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .flush      (flush),
    .pipe_stall (pipe_stall),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_rd     (mdu_rd),
    .mdu_data   (mdu_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fifo_cnt   (fifo_cnt)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Buffered MDU results in arrival order; an entry is in the queue only from
  // the cycle after its push, which is exactly when it may be granted.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  int            head_wait;   // cycles the current head has been passed over
  logic          e_we;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  bit            m_stall;
  bit            m_push;
  bit            m_force;
  int            stall_seen;

  task automatic model_reset();
    mq.delete();
    head_wait = 0;
    e_we      = 1'b0;
    e_waddr   = '0;
    e_wdata   = '0;
    m_stall   = 1'b0;
    m_push    = 1'b0;
    m_force   = 1'b0;
  endtask

  function automatic bit force_due();
    return (mq.size() != 0) && (head_wait >= STARVE_MAX);
  endfunction

  // One clock cycle. Entered at a negedge, returns at the next negedge after
  // checking the registered outputs produced by this cycle's decision.
  task automatic step(input logic pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                      input logic fl, input logic mv, input logic [AW-1:0] mrd,
                      input logic [DW-1:0] md);
    bit preq;
    bit head_ok;
    bit pop;
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_data  = pd;
    flush      = fl;
    mdu_valid  = mv;
    mdu_rd     = mrd;
    mdu_data   = md;
    #1;
    head_ok = (mq.size() != 0);
    m_force = force_due();
    preq    = pv && !fl;
    m_stall = m_force && preq;
    check_val("mdu_ready", {31'd0, mdu_ready}, {31'd0, (mq.size() < DEPTH)});
    check_val("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_stall});
    if (pipe_stall) stall_seen++;
    m_push = mv && (mq.size() < DEPTH);
    pop    = 1'b0;
    if (m_force || (!preq && head_ok)) begin
      e_we    = (mq[0].rd != 0);
      e_waddr = mq[0].rd;
      e_wdata = mq[0].data;
      pop     = 1'b1;
    end else if (preq) begin
      e_we    = (prd != 0);
      e_waddr = prd;
      e_wdata = pd;
    end else begin
      e_we    = 1'b0;
    end
    if (pop) begin
      void'(mq.pop_front());
      head_wait = 0;
    end else if (head_ok) begin
      head_wait++;
    end else begin
      head_wait = 0;
    end
    if (m_push) mq.push_back('{rd: mrd, data: md});
    @(negedge clk);
    check_val("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    check_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_waddr});
    check_val("rf_wdata", {16'd0, rf_wdata}, {16'd0, e_wdata});
    check_val("fifo_cnt", {30'd0, fifo_cnt}, mq.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int            hits;
    int            idx;
    int            ff_cnt;
    bit            lo_ready;
    logic          pv;
    logic          fl;
    logic          mv;
    logic [AW-1:0] prd;
    logic [AW-1:0] mrd;
    logic [DW-1:0] pd;
    logic [DW-1:0] md;

    rst_n      = 1'b0;
    pipe_valid = 1'b0;
    pipe_rd    = '0;
    pipe_data  = '0;
    flush      = 1'b0;
    mdu_valid  = 1'b0;
    mdu_rd     = '0;
    mdu_data   = '0;
    stall_seen = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check_val("rst_wdata", {16'd0, rf_wdata}, 32'd0);
    check_val("rst_cnt", {30'd0, fifo_cnt}, 32'd0);
    check_val("rst_ready", {31'd0, mdu_ready}, 32'd1);
    check_val("rst_stall", {31'd0, pipe_stall}, 32'd0);
    @(negedge clk);

    // Idle drain: push at handshake cycle, write two cycles later.
    idle(9);
    step(1'b0, '0, '0, 1'b0, 1'b1, 5'd3, 16'h1234);
    check_val("drain_early_we", {31'd0, rf_we}, 32'd0);
    idle(1);
    check_val("drain_we", {31'd0, rf_we}, 32'd1);
    check_val("drain_waddr", {27'd0, rf_waddr}, 32'd3);
    check_val("drain_wdata", {16'd0, rf_wdata}, 32'h1234);
    check_val("drain_cnt", {30'd0, fifo_cnt}, 32'd0);

    // Starvation: continuous pipe traffic, one MDU result forced through.
    stall_seen = 0;
    hits       = 0;
    pd         = 16'h5000;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'd5, pd, 1'b0, (i == 0), 5'd7, 16'hBEEF);
      if (rf_we && rf_waddr == 5'd7 && rf_wdata == 16'hBEEF) hits++;
      if (!m_stall) pd = pd + 16'd1;
    end
    check_val("starve_stalls", stall_seen, 32'd1);
    check_val("starve_mdu_writes", hits, 32'd1);

    // Full FIFO: three results against continuous pipe traffic.
    idx      = 0;
    hits     = 0;
    lo_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (!mdu_ready) lo_ready = 1'b1;
      step(1'b1, 5'd9, 16'h0909, 1'b0, (idx < 3), 5'(10 + idx), 16'hA000 + 16'(idx));
      if (m_push) idx++;
      if (rf_we && rf_waddr >= 5'd10 && rf_waddr <= 5'd12) hits++;
    end
    check_val("full_saw_not_ready", {31'd0, lo_ready}, 32'd1);
    check_val("full_pushed", idx, 32'd3);
    check_val("full_delivered", hits, 32'd3);
    check_val("full_cnt_end", {30'd0, fifo_cnt}, 32'd0);

    // x0 writes are consumed but never reach the register file.
    step(1'b1, 5'd0, 16'hFFFF, 1'b0, 1'b0, '0, '0);
    check_val("x0_pipe_we", {31'd0, rf_we}, 32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 5'd0, 16'hFFFF);
    check_val("x0_mdu_cnt_in", {30'd0, fifo_cnt}, 32'd1);
    idle(1);
    check_val("x0_mdu_we", {31'd0, rf_we}, 32'd0);
    check_val("x0_mdu_cnt_out", {30'd0, fifo_cnt}, 32'd0);

    // Flush coinciding with the forced cycle.
    stall_seen = 0;
    hits       = 0;
    ff_cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      fl = force_due();
      if (fl) ff_cnt++;
      step(1'b1, 5'd5, 16'h5555, fl, (i == 0), 5'd6, 16'h6666);
      if (rf_we && rf_waddr == 5'd6) hits++;
    end
    check_val("flushforce_cycles", ff_cnt, 32'd1);
    check_val("flushforce_stalls", stall_seen, 32'd0);
    check_val("flushforce_head", hits, 32'd1);

    // Asynchronous reset with two buffered results.
    step(1'b1, 5'd5, 16'h0101, 1'b0, 1'b1, 5'd8, 16'h0808);
    step(1'b1, 5'd5, 16'h0101, 1'b0, 1'b1, 5'd9, 16'h0909);
    check_val("pre_rst_cnt", {30'd0, fifo_cnt}, 32'd2);
    pipe_valid = 1'b0;
    mdu_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_we", {31'd0, rf_we}, 32'd0);
    check_val("arst_cnt", {30'd0, fifo_cnt}, 32'd0);
    check_val("arst_ready", {31'd0, mdu_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (rf_we) hits++;
    end
    check_val("post_rst_writes", hits, 32'd0);

    // Random traffic with protocol holds.
    pv = 1'b0; prd = '0; pd = '0; mv = 1'b0; mrd = '0; md = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_stall) begin
        pv  = ($urandom_range(0, 9) < 7);
        prd = 5'($urandom_range(0, 31));
        pd  = 16'($urandom);
      end
      if (!(mv && !m_push)) begin
        mv  = ($urandom_range(0, 9) < 4);
        mrd = 5'($urandom_range(0, 31));
        md  = 16'($urandom);
      end
      fl = ($urandom_range(0, 9) == 0);
      step(pv, prd, pd, fl, mv, mrd, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stage (output of the WB select mux) and the multi-cycle mul/div unit (MDU).
- MDU results are held in a small FIFO, which drains into idle write-port slots.
- An anti-starvation counter forces the FIFO to drain, stalling the pipeline for one cycle.
- Sits between WB and the register file; all register-file write signals come out of registers.

Parameters:
- DW, 16, data width (matches DATABUS).
- AW, 5, register address width.
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, number of cycles a FIFO head may wait before it is forced to win.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  WB stage has a write this cycle.
- pipe_rd  in  AW  WB destination register.
- pipe_data  in  DW  WB_data from the writeback mux.
- flush  in  1  kill the current pipe request; the MDU FIFO is not affected.
- pipe_stall  out  1  pipe request not accepted this cycle; hold the WB stage.
- mdu_valid  in  1  MDU result available.
- mdu_ready  out  1  FIFO can accept a result.
- mdu_rd  in  AW  MDU destination register.
- mdu_data  in  DW  MDU result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  DW  register-file write data.
- fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy (debug/hazard use).

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, fifo_cnt=0, mdu_ready=1, pipe_stall=0.
  - State: FIFO pointers=0, age=0, FSM=NORMAL.
  - Asserting reset mid-operation discards all buffered results.
- FIFO push: mdu_valid & mdu_ready.
  - mdu_ready = (cnt != DEPTH), computed from the registered count.
  - There is no same-cycle push-when-full, even if a pop occurs in the same cycle.
- Eligibility: a pushed entry can be granted at the earliest in the cycle after the push (no bypass).
  - Minimum MDU latency: handshake at cycle N → rf_we at N+2.
- pipe_req = pipe_valid & ~flush. head_valid = (cnt != 0).
- FSM states:
  - NORMAL: pipe has priority. If pipe_req, grant pipe; otherwise, if head_valid, grant head (pop).
  - NORMAL → FORCE when head_valid & age == STARVE_MAX-1 & the head is not granted this cycle.
  - FORCE: grant head (pop) unconditionally; pipe_stall = pipe_req.
  - FORCE → NORMAL always after one cycle.
- Age counter:
  - Cleared on any pop and whenever the FIFO is empty.
  - Otherwise increments while head_valid and the head is not granted.
  - Saturates at STARVE_MAX-1.
- pipe_stall = 1 only in FORCE with pipe_req; it is combinational from the registered state.
  - The stalled pipe request must be held stable by WB and is granted next cycle.
- Output register:
  - On a grant: rf_waddr/rf_wdata = the winner's rd/data; rf_we = (rd != 0). Writes to x0 are consumed but not written.
  - No grant: rf_we=0; waddr/wdata hold their previous values.
  - Latency is one cycle from grant to rf_we.
- Ordering between a pipe write and a buffered MDU write to the same rd is the issue logic's responsibility. fifo_cnt is provided so issue logic can enforce it; the arbiter does no address comparison.
- Simultaneous push and pop: cnt is unchanged, and pointers advance independently with wrap at DEPTH.
- flush during FORCE: pipe_req=0, so pipe_stall=0; the head still pops.

Decomposition:
- Shared package/include (para.v): add the WB arbitration state encodings (ARB_NORMAL, ARB_FORCE) next to the WB_* select constants. Reuse DATABUS.
- One sub-module: wb_result_fifo, a synchronous FIFO with DW+AW width, DEPTH entries, async active-low reset, and count output. The arbiter FSM, age counter and output register stay in the top module.

Test Plan:
- Reset mid-stream: cnt=2, rst_n pulsed low asynchronously → rf_we=0, fifo_cnt=0, mdu_ready=1 immediately; no write after release.
- Idle drain: pipe_valid=0; MDU pushes rd=3, data=0x1234 at cycle 10 → rf_we=1, rf_waddr=3, rf_wdata=0x1234 at cycle 12; fifo_cnt back to 0.
- Starvation: pipe_valid=1 every cycle with rd=5; one MDU push of rd=7, data=0xBEEF.
  - Pipe writes for STARVE_MAX=4 cycles.
  - Then one cycle with pipe_stall=1 and an rd=7 write 0xBEEF.
  - Then the pipe resumes with its held rd=5 data.
- Full: DEPTH=2 with continuous pipe traffic; push two entries → mdu_ready=0, and a third mdu_valid is held off until a pop. No result is lost or duplicated (scoreboard check).
- x0 drop: pipe rd=0, data=0xFFFF → rf_we stays 0 and no stall; the same for an MDU entry with rd=0, which still pops (fifo_cnt decrements).
- Flush in FORCE: force cycle coincides with pipe_valid=1, flush=1 → pipe_stall=0, head written, no pipe write.
